// File: rtl/smmha_package.sv
// Shared types and constants for the smmha engine datapath.
package smmha_package;

   localparam int MAC_CNT_LEN = 1024;
   localparam int MAC_CNT_W   = $clog2(MAC_CNT_LEN) + 1;

   localparam logic [2:0] SMMHA_OP_PASS = 3'd0;
   localparam logic [2:0] SMMHA_OP_ADD  = 3'd1;
   localparam logic [2:0] SMMHA_OP_SUB  = 3'd2;
   localparam logic [2:0] SMMHA_OP_MUL  = 3'd3;
   localparam logic [2:0] SMMHA_OP_SHL  = 3'd4;
   localparam logic [2:0] SMMHA_OP_SHR  = 3'd5;
   localparam logic [2:0] SMMHA_OP_AND  = 3'd6;
   localparam logic [2:0] SMMHA_OP_XOR  = 3'd7;

   typedef struct packed {
      logic        clear;
      logic        start;
      logic [31:0] len;
      logic [31:0] operand;
      logic [31:0] operaton;
   } ctrl_engine_t;

   typedef struct packed {
      logic [MAC_CNT_W-1:0] cnt;
      logic                 done;
   } flags_engine_t;

   typedef enum logic [1:0] {ENG_IDLE, ENG_RUN, ENG_DONE} state_engine_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Minimal valid/ready/data/strb stream interface used by the engine ports.
interface hwpe_stream_intf_stream #(
   parameter int DATA_WIDTH = 32
) ();
   logic                    valid;
   logic                    ready;
   logic [DATA_WIDTH-1:0]   data;
   logic [DATA_WIDTH/8-1:0] strb;

   modport source (output valid, data, strb, input ready);
   modport sink   (input valid, data, strb, output ready);
endinterface

// File: rtl/smmha_alu.sv
// Combinational element-wise operator f(a, operand, op).
// With SMMHA_SAT_EN defined, ADD/SUB are signed and saturating.
module smmha_alu
   import smmha_package::*;
(
   input  logic [31:0] a,
   input  logic [31:0] operand,
   input  logic [2:0]  op,
   output logic [31:0] res
);
   logic [31:0] sum;
   logic [31:0] diff;
   logic [31:0] prod;
   logic [31:0] add_res;
   logic [31:0] sub_res;

   assign sum  = a + operand;
   assign diff = a - operand;
   assign prod = a * operand;

`ifdef SMMHA_SAT_EN
   logic        add_ovf;
   logic        sub_ovf;
   logic [31:0] sat_val;

   // Overflow is only possible when the result sign disagrees with a's sign.
   assign add_ovf = (a[31] == operand[31]) && (sum[31]  != a[31]);
   assign sub_ovf = (a[31] != operand[31]) && (diff[31] != a[31]);
   assign sat_val = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
   assign add_res = add_ovf ? sat_val : sum;
   assign sub_res = sub_ovf ? sat_val : diff;
`else
   assign add_res = sum;
   assign sub_res = diff;
`endif

   always_comb begin
      res = a;
      case (op)
         SMMHA_OP_PASS: res = a;
         SMMHA_OP_ADD:  res = add_res;
         SMMHA_OP_SUB:  res = sub_res;
         SMMHA_OP_MUL:  res = prod;
         SMMHA_OP_SHL:  res = a << operand[4:0];
         SMMHA_OP_SHR:  res = a >> operand[4:0];
         SMMHA_OP_AND:  res = a & operand;
         SMMHA_OP_XOR:  res = a ^ operand;
         default:       res = a;
      endcase
   end

endmodule

// File: rtl/smmha_engine.sv
// smmha datapath stage: FSM, counters and registered output for a[i] OP operand.
// Optional SMMHA_SAT_EN selects saturating signed ADD/SUB inside smmha_alu.
module smmha_engine
   import smmha_package::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_MAX    = MAC_CNT_LEN
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   test_mode_i,
   hwpe_stream_intf_stream.sink   a,
   hwpe_stream_intf_stream.source d,
   input  ctrl_engine_t           ctrl_i,
   output flags_engine_t          flags_o
);
   localparam int CW = $clog2(CNT_MAX) + 1;

   state_engine_t           state_reg;
   logic [2:0]              op_reg;
   logic [31:0]             operand_reg;
   logic [CW-1:0]           len_reg;
   logic [CW-1:0]           in_cnt_reg;
   logic [CW-1:0]           cnt_reg;
   logic                    d_valid_reg;
   logic [DATA_WIDTH-1:0]   d_data_reg;
   logic [DATA_WIDTH/8-1:0] d_strb_reg;
   logic                    done_reg;

   logic                    a_hs;
   logic                    d_hs;
   logic [31:0]             alu_res;
   logic [CW-1:0]           len_eff;
   logic                    unused_bits;

   assign unused_bits = ^{test_mode_i, ctrl_i.operaton[31:3]};

   assign len_eff = (ctrl_i.len > 32'(CNT_MAX)) ? CW'(CNT_MAX) : CW'(ctrl_i.len);

   assign a.ready = (state_reg == ENG_RUN) && (in_cnt_reg < len_reg)
                    && (!d_valid_reg || d.ready);
   assign a_hs    = a.valid && a.ready;
   assign d_hs    = d_valid_reg && d.ready;

   smmha_alu u_alu (
      .a       (a.data),
      .operand (operand_reg),
      .op      (op_reg),
      .res     (alu_res)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg   <= ENG_IDLE;
         op_reg      <= '0;
         operand_reg <= '0;
         len_reg     <= '0;
         in_cnt_reg  <= '0;
         cnt_reg     <= '0;
         d_valid_reg <= 1'b0;
         d_data_reg  <= '0;
         d_strb_reg  <= '0;
         done_reg    <= 1'b0;
      end else if (ctrl_i.clear) begin
         // Abort: the held word is dropped without a d handshake.
         state_reg   <= ENG_IDLE;
         in_cnt_reg  <= '0;
         cnt_reg     <= '0;
         d_valid_reg <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         case (state_reg)
            ENG_IDLE: begin
               done_reg <= 1'b0;
               if (ctrl_i.start) begin
                  op_reg      <= ctrl_i.operaton[2:0];
                  operand_reg <= ctrl_i.operand;
                  len_reg     <= len_eff;
                  in_cnt_reg  <= '0;
                  cnt_reg     <= '0;
                  if (len_eff == '0) begin
                     state_reg <= ENG_DONE;
                     done_reg  <= 1'b1;
                  end else begin
                     state_reg <= ENG_RUN;
                  end
               end
            end
            ENG_RUN: begin
               if (a_hs) begin
                  in_cnt_reg  <= in_cnt_reg + CW'(1);
                  d_data_reg  <= alu_res;
                  d_strb_reg  <= a.strb;
                  d_valid_reg <= 1'b1;
               end else if (d_hs) begin
                  d_valid_reg <= 1'b0;
               end
               if (d_hs) begin
                  cnt_reg <= cnt_reg + CW'(1);
                  if ((cnt_reg + CW'(1)) == len_reg) begin
                     state_reg <= ENG_DONE;
                     done_reg  <= 1'b1;
                  end
               end
            end
            ENG_DONE: begin
               done_reg  <= 1'b0;
               state_reg <= ENG_IDLE;
            end
            default: begin
               state_reg <= ENG_IDLE;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign d.valid      = d_valid_reg;
   assign d.data       = d_data_reg;
   assign d.strb       = d_strb_reg;
   assign flags_o.cnt  = MAC_CNT_W'(cnt_reg);
   assign flags_o.done = done_reg;

endmodule

// File: tb/tb_smmha_engine.sv
// Self-checking bench for smmha_engine against a behavioural reference of f and the job rules.
module tb_smmha_engine;
   import smmha_package::*;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          test_mode = 1'b0;
   ctrl_engine_t  ctrl;
   flags_engine_t flags;

   hwpe_stream_intf_stream #(.DATA_WIDTH(32)) a_if ();
   hwpe_stream_intf_stream #(.DATA_WIDTH(32)) d_if ();

   always #5 clk = ~clk;

   smmha_engine #(.DATA_WIDTH(32), .CNT_MAX(MAC_CNT_LEN)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .test_mode_i (test_mode),
      .a           (a_if.sink),
      .d           (d_if.source),
      .ctrl_i      (ctrl),
      .flags_o     (flags)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] src_words[$];

   function automatic logic [31:0] ref_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      s;
      logic [63:0] p;
      case (op)
         3'd0: return a;
`ifdef SMMHA_SAT_EN
         3'd1, 3'd2: begin
            s = (op == 3'd1) ? longint'($signed(a)) + longint'($signed(b))
                             : longint'($signed(a)) - longint'($signed(b));
            if (s > 64'sd2147483647)       return 32'h7FFF_FFFF;
            else if (s < -64'sd2147483648) return 32'h8000_0000;
            else                           return s[31:0];
         end
`else
         3'd1: return a + b;
         3'd2: return a - b;
`endif
         3'd3: begin
            p = {32'b0, a} * {32'b0, b};
            return p[31:0];
         end
         3'd4: return a << b[4:0];
         3'd5: return a >> b[4:0];
         3'd6: return a & b;
         default: return a ^ b;
      endcase
   endfunction

   // ready_mode: 0 = d.ready always 1 and a.valid always 1, 1 = d.ready toggles, 2 = random both.
   task automatic run_job(input string name, input logic [2:0] op, input logic [31:0] operand,
                          input logic [31:0] len, input int ready_mode);
      int          len_eff;
      int          n_offer;
      int          budget;
      logic [31:0] exp_data[$];
      logic [3:0]  exp_strb[$];
      int          idx = 0, a_count = 0, d_count = 0, done_count = 0;
      int          done_cycle = -1, last_dhs = -1;
      logic        last_a_hs = 1'b0, stalled = 1'b0, a_hs, d_hs;
      logic [31:0] last_word = '0, stall_data = '0, exp_w;
      logic [3:0]  stall_strb = '0;
      len_eff = (len > 32'(MAC_CNT_LEN)) ? MAC_CNT_LEN : int'(len);
      n_offer = src_words.size();
      budget  = 4 * len_eff + 40;

      @(negedge clk);
      ctrl.start    = 1'b1;
      ctrl.len      = len;
      ctrl.operand  = operand;
      ctrl.operaton = ($urandom() & 32'hFFFF_FFF8) | {29'b0, op};
      @(negedge clk);
      ctrl.start = 1'b0;

      for (int c = 0; c < budget; c++) begin
         if (c > 0) @(negedge clk);
         if (last_a_hs) begin
            exp_w = ref_f(op, last_word, operand);
            n_checks++;
            if (d_if.valid !== 1'b1 || d_if.data !== exp_w) begin
               n_fail++;
               $display("FAIL %s latency: d.valid=%0b d.data=%h, required valid=1 data=%h",
                        name, d_if.valid, d_if.data, exp_w);
            end
         end
         if (stalled) begin
            n_checks++;
            if (d_if.valid !== 1'b1 || d_if.data !== stall_data || d_if.strb !== stall_strb) begin
               n_fail++;
               $display("FAIL %s stall_stable: valid=%0b data=%h strb=%h, required valid=1 data=%h strb=%h",
                        name, d_if.valid, d_if.data, d_if.strb, stall_data, stall_strb);
            end
         end
         if (flags.done === 1'b1) begin
            done_count++;
            if (done_cycle < 0) done_cycle = c;
         end
         if (done_cycle >= 0 && c == done_cycle + 1) break;

         a_if.valid = (idx < n_offer) && (ready_mode != 2 || $urandom_range(0, 3) != 0);
         a_if.data  = (idx < n_offer) ? src_words[idx] : 32'h0;
         a_if.strb  = 4'($urandom());
         case (ready_mode)
            0:       d_if.ready = 1'b1;
            1:       d_if.ready = (c % 2 == 0);
            default: d_if.ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         a_hs = a_if.valid & a_if.ready;
         d_hs = d_if.valid & d_if.ready;
         if (d_hs) begin
            n_checks++;
            if (exp_data.size() == 0) begin
               n_fail++;
               $display("FAIL %s extra_output: d.data=%h, required no handshake", name, d_if.data);
            end else begin
               exp_w = exp_data.pop_front();
               if (d_if.data !== exp_w || d_if.strb !== exp_strb[0]) begin
                  n_fail++;
                  $display("FAIL %s d_word%0d: data=%h strb=%h, required data=%h strb=%h",
                           name, d_count, d_if.data, d_if.strb, exp_w, exp_strb[0]);
               end
               void'(exp_strb.pop_front());
            end
            d_count++;
            last_dhs = c;
         end
         stalled    = d_if.valid & ~d_if.ready;
         stall_data = d_if.data;
         stall_strb = d_if.strb;
         last_a_hs  = a_hs;
         if (a_hs) begin
            exp_data.push_back(ref_f(op, a_if.data, operand));
            exp_strb.push_back(a_if.strb);
            last_word = a_if.data;
            idx++;
            a_count++;
         end
      end
      a_if.valid = 1'b0;
      d_if.ready = 1'b1;

      n_checks++;
      if (done_cycle < 0) begin
         n_fail++;
         $display("FAIL %s timeout: done not seen within %0d cycles, required done pulse", name, budget);
      end
      n_checks++;
      if (a_count != len_eff || d_count != len_eff || exp_data.size() != 0) begin
         n_fail++;
         $display("FAIL %s handshakes: a=%0d d=%0d pending=%0d, required a=%0d d=%0d pending=0",
                  name, a_count, d_count, exp_data.size(), len_eff, len_eff);
      end
      n_checks++;
      if (done_count != 1 || done_cycle != ((len_eff == 0) ? 0 : last_dhs + 1)) begin
         n_fail++;
         $display("FAIL %s done_pulse: count=%0d cycle=%0d, required count=1 cycle=%0d",
                  name, done_count, done_cycle, (len_eff == 0) ? 0 : last_dhs + 1);
      end
      n_checks++;
      if (int'(flags.cnt) != len_eff) begin
         n_fail++;
         $display("FAIL %s cnt_final: cnt=%0d, required %0d", name, flags.cnt, len_eff);
      end
      $display("job %s op=%0d operand=%h len=%0d offered=%0d accepted=%0d out=%0d done_cycle=%0d",
               name, op, operand, len, n_offer, a_count, d_count, done_cycle);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ctrl  = '0;
      a_if.valid = 1'b0;
      a_if.data  = '0;
      a_if.strb  = '0;
      d_if.ready = 1'b1;
      #12;
      n_checks++;
      if (d_if.valid !== 1'b0 || d_if.data !== 32'h0 || d_if.strb !== 4'h0 || a_if.ready !== 1'b0
          || flags.cnt !== '0 || flags.done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: d.valid=%0b data=%h strb=%h a.ready=%0b cnt=%0d done=%0b, required all zero",
                  d_if.valid, d_if.data, d_if.strb, a_if.ready, flags.cnt, flags.done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      $display("reset released");
   endtask

   task automatic test_add();
      src_words = '{32'd1, 32'd2, 32'd3, 32'd4};
      run_job("add_len4", SMMHA_OP_ADD, 32'd10, 32'd4, 0);
   endtask

   task automatic test_mul_stall();
      src_words = '{32'd7, 32'd100, 32'hFFFF_FFFF};
      run_job("mul_toggle", SMMHA_OP_MUL, 32'd3, 32'd3, 1);
   endtask

   task automatic test_overrun();
      src_words = '{32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
      run_job("overrun_len2", SMMHA_OP_XOR, 32'h00FF_00FF, 32'd2, 0);
   endtask

   task automatic test_len_zero();
      src_words = '{32'd1, 32'd2};
      run_job("len_zero", SMMHA_OP_PASS, 32'd0, 32'd0, 0);
   endtask

   task automatic test_saturation();
      src_words = '{32'h7FFF_FFFF};
      run_job("add_ovf", SMMHA_OP_ADD, 32'd1, 32'd1, 0);
      src_words = '{32'h8000_0000};
      run_job("sub_ovf", SMMHA_OP_SUB, 32'd1, 32'd1, 0);
   endtask

   task automatic test_len_clamp();
      src_words.delete();
      for (int i = 0; i < MAC_CNT_LEN + 6; i++) src_words.push_back($urandom());
      run_job("len_clamp", SMMHA_OP_SHR, 32'd3, 32'hFFFF_FFFF, 0);
   endtask

   task automatic test_clear();
      int   acc = 0;
      logic hit = 1'b0;
      @(negedge clk);
      ctrl.start    = 1'b1;
      ctrl.len      = 32'd5;
      ctrl.operand  = 32'd0;
      ctrl.operaton = {29'b0, SMMHA_OP_PASS};
      @(negedge clk);
      ctrl.start = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (c > 0) @(negedge clk);
         if (flags.cnt == 2 && d_if.valid === 1'b1) begin
            hit = 1'b1;
            break;
         end
         a_if.valid = 1'b1;
         a_if.data  = 32'(100 + acc);
         a_if.strb  = 4'hF;
         d_if.ready = 1'b1;
         #1;
         if (a_if.valid & a_if.ready) acc++;
      end
      n_checks++;
      if (!hit) begin
         n_fail++;
         $display("FAIL clear_setup: cnt=%0d d.valid=%0b, required cnt=2 with d.valid=1", flags.cnt, d_if.valid);
      end
      a_if.valid = 1'b0;
      d_if.ready = 1'b0;
      ctrl.clear = 1'b1;
      @(negedge clk);
      ctrl.clear = 1'b0;
      a_if.valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_checks++;
         if (d_if.valid !== 1'b0 || flags.cnt !== '0 || flags.done !== 1'b0 || a_if.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_cycle%0d: d.valid=%0b cnt=%0d done=%0b a.ready=%0b, required 0 0 0 0",
                     c, d_if.valid, flags.cnt, flags.done, a_if.ready);
         end
         @(negedge clk);
      end
      a_if.valid = 1'b0;
      d_if.ready = 1'b1;
      $display("clear mid-job after %0d accepted words", acc);
      src_words = '{32'd20, 32'd30, 32'd40};
      run_job("after_clear", SMMHA_OP_SUB, 32'd5, 32'd3, 0);
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] operand;
      int          len;
      for (int j = 0; j < 10; j++) begin
         op      = 3'($urandom_range(0, 7));
         operand = $urandom();
         len     = $urandom_range(0, 12);
         src_words.delete();
         for (int i = 0; i < len + int'($urandom_range(0, 3)); i++) src_words.push_back($urandom());
         run_job($sformatf("random%0d", j), op, operand, 32'(len), 2);
      end
   endtask

   task automatic test_back_to_back();
      src_words = '{32'h1234_5678, 32'h8000_0001};
      run_job("b2b_shl", SMMHA_OP_SHL, 32'hFFFF_FFE4, 32'd2, 0);
      src_words = '{32'hF0F0_F0F0, 32'h0F0F_0F0F};
      run_job("b2b_and", SMMHA_OP_AND, 32'h3C3C_3C3C, 32'd2, 2);
   endtask

   initial begin
      test_reset();
      test_add();
      test_mul_stall();
      test_overrun();
      test_len_zero();
      test_saturation();
      test_clear();
      test_back_to_back();
      test_random();
      test_len_clamp();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
